fp_div_unit: RTL and testbench
==============================

Name: fp_div_unit

Overview:
- Multi-cycle IEEE-754 single-precision divider. It is the inverse-operation companion of the FP multiply unit and sits beside it in the FPU execute stage.
- It accepts one operand pair, runs a radix-2 restoring mantissa division, and normalizes and rounds the quotient (round-to-nearest-even).
- It presents the result and exception flags to the round/writeback path for exactly one cycle.

Parameters:
- MANT_W, 24, mantissa width including hidden bit.
- Q_W, 26, quotient bits produced (24 + round + 1 extra for the normalization shift); equals the DIVIDE-state cycle count.
- BIAS, 127, exponent bias.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active high.
- clk_en_i  in  1  global stall; when 0, all state, counters and outputs hold.
- valid_i  in  1  operands valid; sampled only in IDLE.
- dividend_i  in  32  float_t {sign, exponent[7:0], mantissa[22:0]}.
- divisor_i  in  32  float_t.
- to_round_unit_o  out  32  quotient.
- valid_o  out  1  result valid; 1-cycle pulse.
- fu_state_o  out  fu_state_e  FREE in IDLE, else BUSY.
- overflow_o  out  1  exponent overflow.
- underflow_o  out  1  exponent underflow.
- div_by_zero_o  out  1  finite nonzero / zero.
- invalid_op_o  out  1  0/0, inf/inf, or signaling NaN input.

Behaviour:
- Single clock clk_i. rst_i is synchronous and active high. While rst_i=1: state=IDLE, counter=0, all data/flag registers=0, valid_o=0, fu_state_o=FREE. Reset mid-operation aborts the operation; no valid_o is ever produced for it.
- clk_en_i=0 freezes everything, including VALID; valid_o then stays high until the next enabled edge.
- FSM states: IDLE, PREPARE, DIVIDE, NORMALIZE, VALID.
  - IDLE -> PREPARE when valid_i=1. The operands are registered at that edge; valid_i is ignored in every other state.
  - PREPARE: classify operands and compute the sign. If a special case applies, load the special result and flags, then -> VALID. Otherwise compute exp = eA - eB + BIAS (10-bit signed), load R=mA, D=mB, clear Q and the counter, then -> DIVIDE.
  - DIVIDE: one quotient bit per cycle. If R >= D: bit=1 and R = R - D; else bit=0. Then R = R << 1 and Q = {Q[24:0], bit}. After Q_W cycles (counter = Q_W-1) -> NORMALIZE.
  - NORMALIZE (rounding and exponent range checks, below) -> VALID.
  - VALID: valid_o=1 for one cycle -> IDLE.
- Latency from valid_i accepted at edge N: normal path gives valid_o high during cycle N+29; special path gives valid_o during cycle N+2. Back-to-back issue is allowed: a new valid_i may be accepted on the cycle after VALID.
- Operand rules:
  - Hidden bit = |exponent. Exponent 0 is zero (subnormals flushed to zero).
  - Result sign = sA ^ sB in all cases except NaN results.
- Quotient normalization: Q[25] has weight 2^0, so Q lies in [0.5, 2).
  - If Q[25]=1: mant=Q[24:2], rnd=Q[1], sticky=Q[0]|(R!=0).
  - Else: mant=Q[23:1], rnd=Q[0], sticky=(R!=0), exp=exp-1.
  - Round-to-nearest-even: increment mant if rnd & (sticky | mant[0]). If the increment carries out, set mant=0 and exp=exp+1.
- Range checks:
  - exp >= 255: result {sign, 8'hFF, 0}, overflow_o=1.
  - exp <= 0: result {sign, 8'h00, 0}, underflow_o=1.
- Special cases, in priority order:
  1. Either operand NaN -> CANO_NAN (0x7FC00000). invalid_op_o=1 if either NaN has mantissa[22]=0.
  2. 0/0 or inf/inf -> CANO_NAN, invalid_op_o=1.
  3. inf/x -> ±inf.
  4. finite nonzero/0 -> ±inf, div_by_zero_o=1.
  5. 0/x or x/inf -> ±0.
- Outputs are registered. Flags not asserted by the current operation are 0. Result and flags hold their values from VALID until the next PREPARE.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> 0x40400000, all flags 0, valid_o exactly 29 cycles after acceptance, fu_state_o BUSY throughout.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (round-up path). 0xC0C00000 / 0x40000000 -> 0xC0400000.
- 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero_o=1, valid_o 2 cycles after acceptance. 0/0 -> 0x7FC00000, invalid_op_o=1. 0x7F800001 / 1.0 (sNaN) -> 0x7FC00000, invalid_op_o=1.
- 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow_o=1. 0x00800000 / 0x40000000 -> 0x00000000, underflow_o=1.
- Assert rst_i during DIVIDE cycle 10 -> IDLE, outputs 0, no valid_o. Hold clk_en_i=0 for 5 cycles mid-DIVIDE -> result unchanged, latency extended by exactly 5 cycles.
- valid_i held high continuously with changing operands -> only the operands present in IDLE are used. Two back-to-back 6/2 operations each pulse valid_o once, with 30 cycles between pulses.

Source files
------------

// File: rtl/fp_div_unit.sv
// Multi-cycle IEEE-754 single-precision divider: radix-2 restoring mantissa
// division followed by normalization and round-to-nearest-even.
package fp_div_pkg;
    typedef enum logic {FREE = 1'b0, BUSY = 1'b1} fu_state_e;
endpackage

module fp_div_unit
    import fp_div_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int Q_W    = 26,
    parameter int BIAS   = 127
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_i,
    input  logic        valid_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] to_round_unit_o,
    output logic        valid_o,
    output fu_state_e   fu_state_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        div_by_zero_o,
    output logic        invalid_op_o
);
    localparam int          CNT_W    = $clog2(Q_W);
    localparam logic [31:0] CANO_NAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_PREPARE, S_DIVIDE, S_NORMALIZE, S_VALID
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             a_q, a_d, b_q, b_d;
    logic                    sign_q, sign_d;
    logic signed [9:0]       exp_q, exp_d;
    logic [MANT_W:0]         rem_q, rem_d;
    logic [MANT_W-1:0]       dvsr_q, dvsr_d;
    logic [Q_W-1:0]          quo_q, quo_d;
    logic [31:0]             res_q, res_d;
    logic                    ovf_q, ovf_d, unf_q, unf_d;
    logic                    dbz_q, dbz_d, inv_q, inv_d;
    logic                    valid_q, valid_d;

    // operand classification (subnormals are treated as zero)
    logic [7:0]        ea, eb;
    logic [22:0]       ma, mb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [9:0] ea_s, eb_s;

    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        ma     = a_q[22:0];
        mb     = b_q[22:0];
        ea_s   = {2'b00, ea};
        eb_s   = {2'b00, eb};
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (ma == '0);
        b_inf  = (eb == 8'hFF) && (mb == '0);
        a_nan  = (ea == 8'hFF) && (ma != '0);
        b_nan  = (eb == 8'hFF) && (mb != '0);
    end

    // one restoring-division step
    logic            rem_ge;
    logic [MANT_W:0] rem_sub;

    always_comb begin
        rem_ge  = (rem_q >= {1'b0, dvsr_q});
        rem_sub = rem_ge ? (rem_q - {1'b0, dvsr_q}) : rem_q;
    end

    // normalize + round; Q[Q_W-1] carries weight 2^0
    logic [MANT_W-2:0] mant_pre, mant_fin;
    logic [MANT_W-1:0] mant_inc;
    logic              rnd, sticky;
    logic signed [9:0] exp_n, exp_r;

    always_comb begin
        if (quo_q[Q_W-1]) begin
            mant_pre = quo_q[Q_W-2 -: MANT_W-1];
            rnd      = quo_q[Q_W-MANT_W-1];
            sticky   = quo_q[0] | (|rem_q);
            exp_n    = exp_q;
        end else begin
            mant_pre = quo_q[Q_W-3 -: MANT_W-1];
            rnd      = quo_q[0];
            sticky   = |rem_q;
            exp_n    = exp_q - 10'sd1;
        end
        mant_inc = {1'b0, mant_pre} + {{(MANT_W-1){1'b0}}, 1'b1};
        mant_fin = mant_pre;
        exp_r    = exp_n;
        if (rnd & (sticky | mant_pre[0])) begin
            if (mant_inc[MANT_W-1]) begin
                mant_fin = '0;
                exp_r    = exp_n + 10'sd1;
            end else begin
                mant_fin = mant_inc[MANT_W-2:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        quo_d   = quo_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        dbz_d   = dbz_q;
        inv_d   = inv_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    a_d     = dividend_i;
                    b_d     = divisor_i;
                    state_d = S_PREPARE;
                end
            end
            S_PREPARE: begin
                sign_d  = a_q[31] ^ b_q[31];
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                dbz_d   = 1'b0;
                inv_d   = 1'b0;
                state_d = S_VALID;
                if (a_nan || b_nan) begin
                    res_d = CANO_NAN;
                    inv_d = (a_nan && !ma[22]) || (b_nan && !mb[22]);
                end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                    res_d = CANO_NAN;
                    inv_d = 1'b1;
                end else if (a_inf) begin
                    res_d = {sign_d, 8'hFF, 23'd0};
                end else if (b_zero) begin
                    res_d = {sign_d, 8'hFF, 23'd0};
                    dbz_d = 1'b1;
                end else if (a_zero || b_inf) begin
                    res_d = {sign_d, 31'd0};
                end else begin
                    exp_d   = ea_s - eb_s + 10'(BIAS);
                    rem_d   = {2'b01, ma};
                    dvsr_d  = {1'b1, mb};
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                rem_d = {rem_sub[MANT_W-1:0], 1'b0};
                quo_d = {quo_q[Q_W-2:0], rem_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(Q_W-1))
                    state_d = S_NORMALIZE;
            end
            S_NORMALIZE: begin
                if (exp_r >= 10'sd255) begin
                    res_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d = 1'b1;
                end else if (exp_r <= 10'sd0) begin
                    res_d = {sign_q, 31'd0};
                    unf_d = 1'b1;
                end else begin
                    res_d = {sign_q, exp_r[7:0], mant_fin};
                end
                state_d = S_VALID;
            end
            S_VALID: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        valid_d = (state_d == S_VALID);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            inv_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (clk_en_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            dbz_q   <= dbz_d;
            inv_q   <= inv_d;
            valid_q <= valid_d;
        end
    end

    assign to_round_unit_o = res_q;
    assign valid_o         = valid_q;
    assign fu_state_o      = (state_q == S_IDLE) ? FREE : BUSY;
    assign overflow_o      = ovf_q;
    assign underflow_o     = unf_q;
    assign div_by_zero_o   = dbz_q;
    assign invalid_op_o    = inv_q;
endmodule

// File: tb/tb_fp_div_unit.sv
// Bench for fp_div_unit: directed cases plus randomized operands checked
// against an integer-arithmetic model of IEEE single-precision division.
module tb_fp_div_unit;
    import fp_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        clk_en_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [31:0] to_round_unit_o;
    logic        valid_o;
    fu_state_e   fu_state_o;
    logic        overflow_o, underflow_o, div_by_zero_o, invalid_op_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    fp_div_unit dut (
        .clk_i(clk), .rst_i(rst_i), .clk_en_i(clk_en_i), .valid_i(valid_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i),
        .to_round_unit_o(to_round_unit_o), .valid_o(valid_o),
        .fu_state_o(fu_state_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .div_by_zero_o(div_by_zero_o),
        .invalid_op_o(invalid_op_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [3:0] flags();
        return {overflow_o, underflow_o, div_by_zero_o, invalid_op_o};
    endfunction

    // Reference: flags = {ovf, unf, dbz, inv}; lat = cycles from acceptance to valid_o
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
        logic s = a[31] ^ b[31];
        bit a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bit b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        bit a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bit b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        bit a_zer = (a[30:23] == 0);
        bit b_zer = (b[30:23] == 0);
        longint ma, mb, num, q, rem, sig;
        int e;
        bit g, st;
        f = 4'b0000;
        lat = 2;
        if (a_nan || b_nan) begin
            r = 32'h7FC00000;
            f[0] = (a_nan && !a[22]) || (b_nan && !b[22]);
        end else if ((a_zer && b_zer) || (a_inf && b_inf)) begin
            r = 32'h7FC00000; f[0] = 1'b1;
        end else if (a_inf) begin
            r = {s, 8'hFF, 23'd0};
        end else if (b_zer) begin
            r = {s, 8'hFF, 23'd0}; f[1] = 1'b1;
        end else if (a_zer || b_inf) begin
            r = {s, 31'd0};
        end else begin
            lat = 29;
            ma = longint'({1'b1, a[22:0]});
            mb = longint'({1'b1, b[22:0]});
            num = ma << 25;
            q = num / mb;
            rem = num % mb;
            e = int'(a[30:23]) - int'(b[30:23]) + 127;
            if (q >= (64'd1 << 25)) begin
                sig = q >> 2; g = q[1]; st = q[0] || (rem != 0);
            end else begin
                e = e - 1; sig = q >> 1; g = q[0]; st = (rem != 0);
            end
            if (g && (st || sig[0])) sig = sig + 1;
            if (sig == (64'd1 << 24)) begin sig = 64'd1 << 23; e = e + 1; end
            if (e >= 255) begin r = {s, 8'hFF, 23'd0}; f[3] = 1'b1; end
            else if (e <= 0) begin r = {s, 31'd0}; f[2] = 1'b1; end
            else begin
                logic [31:0] ev = e;
                r = {s, ev[7:0], sig[22:0]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        int sel = $urandom_range(0, 19);
        logic s = 1'($urandom);
        logic [22:0] m = 23'($urandom);
        logic [7:0] e = 8'($urandom_range(64, 190));
        case (sel)
            0: return {s, 31'd0};
            1: return {s, 8'hFF, 23'd0};
            2: return {s, 8'hFF, 1'b1, m[21:0]};
            3: return {s, 8'hFF, 1'b0, m[21:1], 1'b1};
            4: return {s, 8'h00, m};
            5: return {s, 8'h01, m};
            6: return {s, 8'hFE, m};
            default: return {s, e, m};
        endcase
    endfunction

    // Issue one operation and wait (bounded) for its result
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input int stall_at, input int stall_len,
                         output logic [31:0] r, output logic [3:0] f, output int lat,
                         output bit busy_ok, output bit pulse_ok, output int vcyc);
        dividend_i = a; divisor_i = b; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; dividend_i = $urandom; divisor_i = $urandom;
        lat = -1; busy_ok = 1'b1; pulse_ok = 1'b0; r = '0; f = '0; vcyc = 0;
        for (int k = 0; k < 100; k++) begin
            if (valid_o === 1'b1) begin
                lat = k + 1; r = to_round_unit_o; f = flags(); vcyc = cyc;
                break;
            end
            if (fu_state_o !== BUSY) busy_ok = 1'b0;
            if (k == stall_at) clk_en_i = 1'b0;
            if (k == stall_at + stall_len) clk_en_i = 1'b1;
            @(posedge clk); #1;
        end
        clk_en_i = 1'b1;
        if (lat > 0) begin
            @(posedge clk); #1;
            pulse_ok = (valid_o === 1'b0) && (fu_state_o === FREE) && (to_round_unit_o === r);
        end
    endtask

    task automatic test_reset();
        valid_i = 1'b1; dividend_i = 32'h40C00000; divisor_i = 32'h40000000;
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (fu_state_o !== FREE) begin errors++; $display("FAIL reset_state: got %b want FREE", fu_state_o); end
        checks++; if (to_round_unit_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", to_round_unit_o); end
        checks++; if (flags() !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags()); end
        valid_i = 1'b0; rst_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [12] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h3F800000,
                                 32'h00000000, 32'h7F800001, 32'h7F000000, 32'h00800000,
                                 32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h40000000};
        logic [31:0] tb [12] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000,
                                 32'h00000000, 32'h3F800000, 32'h3E800000, 32'h40000000,
                                 32'h3F800000, 32'hFF800000, 32'h00000000, 32'h7F800000};
        logic [31:0] tr [12] = '{32'h40400000, 32'h3EAAAAAB, 32'hC0400000, 32'h7F800000,
                                 32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                                 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h00000000};
        logic [3:0]  tf [12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0001,
                                 4'b1000, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        int          tl [12] = '{29, 29, 29, 2, 2, 2, 29, 29, 2, 2, 2, 2};
        logic [31:0] r; logic [3:0] f; int lat, vc; bit bok, pok;
        for (int i = 0; i < 12; i++) begin
            do_op(ta[i], tb[i], -10, 0, r, f, lat, bok, pok, vc);
            checks++; if (r !== tr[i]) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, r, tr[i]); end
            checks++; if (f !== tf[i]) begin errors++; $display("FAIL dir%0d_flags: got %b want %b", i, f, tf[i]); end
            checks++; if (lat !== tl[i]) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]); end
            checks++; if (!bok) begin errors++; $display("FAIL dir%0d_busy: got not-busy want BUSY", i); end
            checks++; if (!pok) begin errors++; $display("FAIL dir%0d_pulse: got pulse/hold 0 want 1", i); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, er; logic [3:0] f, ef; int lat, el, vc; bit bok, pok;
        for (int i = 0; i < 80; i++) begin
            a = rand_op(); b = rand_op();
            model(a, b, er, ef, el);
            do_op(a, b, -10, 0, r, f, lat, bok, pok, vc);
            checks++; if (r !== er) begin errors++; $display("FAIL rnd_result %h/%h: got %h want %h", a, b, r, er); end
            checks++; if (f !== ef) begin errors++; $display("FAIL rnd_flags %h/%h: got %b want %b", a, b, f, ef); end
            checks++; if (lat !== el) begin errors++; $display("FAIL rnd_latency %h/%h: got %0d want %0d", a, b, lat, el); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic [3:0] f; int lat, vc; bit bok, pok, seen;
        dividend_i = 32'h40C00000; divisor_i = 32'h40000000; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        checks++; if (fu_state_o !== FREE) begin errors++; $display("FAIL rstmid_state: got %b want FREE", fu_state_o); end
        checks++; if (to_round_unit_o !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h want 0", to_round_unit_o); end
        checks++; if (flags() !== 4'b0) begin errors++; $display("FAIL rstmid_flags: got %b want 0000", flags()); end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (valid_o !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rstmid_novalid: got valid_o pulse want none"); end
        do_op(32'h40C00000, 32'h40000000, -10, 0, r, f, lat, bok, pok, vc);
        checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL rstmid_recover: got %h want 40400000", r); end
    endtask

    task automatic test_stall();
        logic [31:0] r; logic [3:0] f; int lat, vc; bit bok, pok, held;
        do_op(32'h40C00000, 32'h40000000, 5, 5, r, f, lat, bok, pok, vc);
        checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL stall_result: got %h want 40400000", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL stall_latency: got %0d want 34", lat); end
        // stall while VALID: the pulse must stretch
        dividend_i = 32'h3F800000; divisor_i = 32'h00000000; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        clk_en_i = 1'b0;
        held = (valid_o === 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            if (valid_o !== 1'b1) held = 1'b0;
        end
        checks++; if (!held) begin errors++; $display("FAIL stall_valid_hold: got valid_o dropped want held high"); end
        clk_en_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_valid_release: got %b want 0", valid_o); end
    endtask

    task automatic test_valid_hold();
        logic [31:0] r1, r2; bit to1, to2;
        dividend_i = 32'h40C00000; divisor_i = 32'h40000000; valid_i = 1'b1;
        @(posedge clk); #1;
        to1 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (valid_o === 1'b1) begin to1 = 1'b0; break; end
            dividend_i = $urandom; divisor_i = $urandom;
            @(posedge clk); #1;
        end
        r1 = to_round_unit_o;
        dividend_i = 32'h3F800000; divisor_i = 32'h40400000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        to2 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (valid_o === 1'b1) begin to2 = 1'b0; break; end
            dividend_i = $urandom; divisor_i = $urandom;
            @(posedge clk); #1;
        end
        r2 = to_round_unit_o;
        valid_i = 1'b0;
        @(posedge clk); #1;
        checks++; if (to1 || r1 !== 32'h40400000) begin errors++; $display("FAIL hold_first: got %h timeout=%0d want 40400000", r1, to1); end
        checks++; if (to2 || r2 !== 32'h3EAAAAAB) begin errors++; $display("FAIL hold_second: got %h timeout=%0d want 3EAAAAAB", r2, to2); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2; logic [3:0] f; int l1, l2, c1, c2; bit b1, b2, p1, p2;
        do_op(32'h40C00000, 32'h40000000, -10, 0, r1, f, l1, b1, p1, c1);
        do_op(32'h40C00000, 32'h40000000, -10, 0, r2, f, l2, b2, p2, c2);
        checks++; if (r1 !== 32'h40400000 || r2 !== 32'h40400000) begin errors++; $display("FAIL b2b_results: got %h,%h want 40400000", r1, r2); end
        checks++; if (c2 - c1 !== 30) begin errors++; $display("FAIL b2b_spacing: got %0d want 30", c2 - c1); end
        checks++; if (!p1 || !p2) begin errors++; $display("FAIL b2b_single_pulse: got %0d,%0d want 1,1", p1, p2); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        test_stall();
        test_valid_hold();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
